// File: rtl/branch_resolve_unit_pkg.sv
// rtl/branch_resolve_unit_pkg.sv - shared branch encodings, compare flags and decode helpers
package branch_resolve_unit_pkg;

  localparam int DEFAULT_REG_WIDTH = 32;

  // RV32I conditional-branch funct3 encodings
  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  // Fall-through distance for a 32-bit instruction
  localparam int unsigned PC_INC = 4;

  // Operand comparison results captured in stage 1
  typedef struct packed {
    logic eq;
    logic lts;
    logic ltu;
  } cmp_flags_t;

  // Direction from the registered flags; reserved encodings resolve not-taken
  function automatic logic resolve_taken(input logic [2:0] funct3, input cmp_flags_t flags);
    logic taken;
    taken = 1'b0;
    case (funct3)
      BR_EQ:   taken = flags.eq;
      BR_NE:   taken = !flags.eq;
      BR_LT:   taken = flags.lts;
      BR_GE:   taken = !flags.lts;
      BR_LTU:  taken = flags.ltu;
      BR_GEU:  taken = !flags.ltu;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  // Only 010 and 011 fall outside the six branch encodings
  function automatic logic is_illegal_funct3(input logic [2:0] funct3);
    return !(funct3 inside {BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU});
  endfunction

endpackage

// File: rtl/branch_resolve_unit_pipe_stage_reg.sv
// rtl/branch_resolve_unit_pipe_stage_reg.sv - one valid/ready register slice with flush
module pipe_stage_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kill,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Slot is free when empty or when its content leaves this cycle; kill empties it
  always_comb begin
    in_ready = !valid_q || out_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
    if (kill) begin
      valid_d = 1'b0;
    end
  end

  // Slice state; data is held while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - pipelined branch compare, target, redirect and mispredict stats
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int REG_WIDTH = DEFAULT_REG_WIDTH,
  parameter int PC_WIDTH  = 32,
  parameter int LATENCY   = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 kill,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           funct3,
  input  logic [REG_WIDTH-1:0] data_rs1,
  input  logic [REG_WIDTH-1:0] data_rs2,
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic [PC_WIDTH-1:0]  imm,
  input  logic                 pred_taken,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 br_taken,
  output logic [PC_WIDTH-1:0]  br_target,
  output logic [PC_WIDTH-1:0]  redirect_pc,
  output logic                 mispredict,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] cnt_branches,
  output logic [CNT_WIDTH-1:0] cnt_mispredicts
);

  localparam int S1_W  = 3 + 3 + 1 + 2 * PC_WIDTH;
  localparam int RES_W = 3 + 2 * PC_WIDTH;

  cmp_flags_t          in_flags;
  cmp_flags_t          s1_flags;
  logic [2:0]          s1_funct3;
  logic                s1_pred;
  logic [PC_WIDTH-1:0] s1_target;
  logic [PC_WIDTH-1:0] s1_pc4;
  logic                s1_valid;
  logic                s1_ready;
  logic                s1_in_ready;
  logic [S1_W-1:0]     s1_in_data;
  logic [S1_W-1:0]     s1_out_data;

  logic                res_taken;
  logic                res_mispredict;
  logic                res_illegal;
  logic [PC_WIDTH-1:0] res_redirect;
  logic [RES_W-1:0]    res_in_data;
  logic [RES_W-1:0]    res_out_data;

  logic                 retire;
  logic [CNT_WIDTH-1:0] cnt_branches_q, cnt_branches_d;
  logic [CNT_WIDTH-1:0] cnt_mispredicts_q, cnt_mispredicts_d;

  // Stage-1 payload: compare flags and both candidate PCs; adds wrap modulo 2^PC_WIDTH
  always_comb begin
    in_flags.eq  = (data_rs1 == data_rs2);
    in_flags.lts = ($signed(data_rs1) < $signed(data_rs2));
    in_flags.ltu = (data_rs1 < data_rs2);
    s1_in_data   = {in_flags, funct3, pred_taken, pc + imm, pc + PC_WIDTH'(PC_INC)};
  end

  pipe_stage_reg #(
    .WIDTH (S1_W)
  ) u_stage1 (
    .clk       (clk),
    .rst       (rst),
    .kill      (kill),
    .in_valid  (in_valid),
    .in_ready  (s1_in_ready),
    .in_data   (s1_in_data),
    .out_valid (s1_valid),
    .out_ready (s1_ready),
    .out_data  (s1_out_data)
  );

  // A flush frees every slot, so offers during kill are taken and then dropped
  assign in_ready = s1_in_ready || kill;

  // Resolve direction and redirect from the registered stage-1 fields
  always_comb begin
    {s1_flags, s1_funct3, s1_pred, s1_target, s1_pc4} = s1_out_data;
    res_taken      = resolve_taken(s1_funct3, s1_flags);
    res_illegal    = is_illegal_funct3(s1_funct3);
    res_mispredict = res_taken ^ s1_pred;
    res_redirect   = res_taken ? s1_target : s1_pc4;
    res_in_data    = {res_taken, res_mispredict, res_illegal, s1_target, res_redirect};
  end

  generate
    if (LATENCY == 2) begin : g_lat2
      pipe_stage_reg #(
        .WIDTH (RES_W)
      ) u_stage2 (
        .clk       (clk),
        .rst       (rst),
        .kill      (kill),
        .in_valid  (s1_valid),
        .in_ready  (s1_ready),
        .in_data   (res_in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (res_out_data)
      );
    end else if (LATENCY == 1) begin : g_lat1
      assign s1_ready     = out_ready;
      assign out_valid    = s1_valid;
      assign res_out_data = res_in_data;
    end else begin : g_lat_bad
      $error("branch_resolve_unit: LATENCY must be 1 or 2");
    end
  endgenerate

  // Present the final result fields
  always_comb begin
    {br_taken, mispredict, illegal, br_target, redirect_pc} = res_out_data;
  end

  assign retire = out_valid && out_ready;

  // Saturating statistics; a retire coinciding with kill still counts
  always_comb begin
    cnt_branches_d    = cnt_branches_q;
    cnt_mispredicts_d = cnt_mispredicts_q;
    if (retire && (cnt_branches_q != '1)) begin
      cnt_branches_d = cnt_branches_q + 1'b1;
    end
    if (retire && mispredict && (cnt_mispredicts_q != '1)) begin
      cnt_mispredicts_d = cnt_mispredicts_q + 1'b1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_branches_q    <= '0;
      cnt_mispredicts_q <= '0;
    end else begin
      cnt_branches_q    <= cnt_branches_d;
      cnt_mispredicts_q <= cnt_mispredicts_d;
    end
  end

  assign cnt_branches    = cnt_branches_q;
  assign cnt_mispredicts = cnt_mispredicts_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - randomized and directed bench for both pipeline depths
module tb_branch_resolve_unit;

  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
    logic [31:0] i;
    logic        pr;
  } req_t;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic [31:0] redirect;
    logic        misp;
    logic        illegal;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, kill, in_valid, out_ready, pred, sel;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2, pc, imm;
  int          lat;
  int          checks = 0;
  int          failures = 0;

  logic        iv1, iv2, or1, or2, ir1, ir2, ov1, ov2;
  logic        tk1, tk2, mp1, mp2, il1, il2;
  logic [31:0] tg1, tg2, rd1, rd2;
  logic [3:0]  cb1, cb2, cm1, cm2;

  logic        in_ready_m, ov_m;
  logic [3:0]  cb_m, cm_m;
  exp_t        obs;

  assign iv1 = in_valid & ~sel;
  assign iv2 = in_valid & sel;
  assign or1 = out_ready & ~sel;
  assign or2 = out_ready & sel;

  always_comb begin
    in_ready_m = sel ? ir2 : ir1;
    ov_m       = sel ? ov2 : ov1;
    cb_m       = sel ? cb2 : cb1;
    cm_m       = sel ? cm2 : cm1;
    obs        = sel ? exp_t'({tk2, tg2, rd2, mp2, il2}) : exp_t'({tk1, tg1, rd1, mp1, il1});
  end

  branch_resolve_unit #(.REG_WIDTH(32), .PC_WIDTH(32), .LATENCY(1), .CNT_WIDTH(4)) dut_l1 (
    .clk(clk), .rst(rst), .kill(kill), .in_valid(iv1), .in_ready(ir1), .funct3(funct3),
    .data_rs1(rs1), .data_rs2(rs2), .pc(pc), .imm(imm), .pred_taken(pred),
    .out_valid(ov1), .out_ready(or1), .br_taken(tk1), .br_target(tg1), .redirect_pc(rd1),
    .mispredict(mp1), .illegal(il1), .cnt_branches(cb1), .cnt_mispredicts(cm1)
  );

  branch_resolve_unit #(.REG_WIDTH(32), .PC_WIDTH(32), .LATENCY(2), .CNT_WIDTH(4)) dut_l2 (
    .clk(clk), .rst(rst), .kill(kill), .in_valid(iv2), .in_ready(ir2), .funct3(funct3),
    .data_rs1(rs1), .data_rs2(rs2), .pc(pc), .imm(imm), .pred_taken(pred),
    .out_valid(ov2), .out_ready(or2), .br_taken(tk2), .br_target(tg2), .redirect_pc(rd2),
    .mispredict(mp2), .illegal(il2), .cnt_branches(cb2), .cnt_mispredicts(cm2)
  );

  // Reference: branch semantics straight from the ISA rules
  function automatic exp_t model(input req_t r);
    exp_t e;
    logic t;
    case (r.f)
      3'b000:  t = (r.a == r.b);
      3'b001:  t = (r.a != r.b);
      3'b100:  t = ($signed(r.a) < $signed(r.b));
      3'b101:  t = ($signed(r.a) >= $signed(r.b));
      3'b110:  t = (r.a < r.b);
      3'b111:  t = (r.a >= r.b);
      default: t = 1'b0;
    endcase
    e.taken    = t;
    e.target   = r.p + r.i;
    e.redirect = t ? (r.p + r.i) : (r.p + 32'd4);
    e.misp     = (t != r.pr);
    e.illegal  = (r.f == 3'b010) || (r.f == 3'b011);
    return e;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.f  = 3'($urandom_range(0, 7));
    r.a  = $urandom;
    case ($urandom_range(0, 3))
      0:       r.b = r.a;
      1:       r.b = r.a ^ 32'h8000_0000;
      default: r.b = $urandom;
    endcase
    r.p  = $urandom;
    r.i  = $urandom;
    r.pr = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic drive_req(input req_t r);
    funct3 = r.f; rs1 = r.a; rs2 = r.b; pc = r.p; imm = r.i; pred = r.pr;
  endtask

  task automatic do_reset();
    rst = 1'b1; kill = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic issue_and_wait(input req_t r);
    drive_req(r);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (lat - 1) @(negedge clk);
  endtask

  task automatic retire_one();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; kill = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #2;
    checks++; if (ov_m !== 1'b0) begin failures++; $display("FAIL reset_out_valid L%0d: got %b want 0", lat, ov_m); end
    checks++; if (cb_m !== 4'h0 || cm_m !== 4'h0) begin failures++; $display("FAIL reset_counters L%0d: got %h/%h want 0/0", lat, cb_m, cm_m); end
    checks++; if (obs !== exp_t'(0)) begin failures++; $display("FAIL reset_data L%0d: got %h want 0", lat, obs); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (in_ready_m !== 1'b1) begin failures++; $display("FAIL reset_in_ready L%0d: got %b want 1", lat, in_ready_m); end
    @(negedge clk);
  endtask

  task automatic test_blt_bltu();
    req_t r;
    exp_t e;
    do_reset();
    r = '{f: 3'b100, a: 32'hFFFF_FFFF, b: 32'd1, p: 32'h100, i: 32'h20, pr: 1'b0};
    issue_and_wait(r);
    checks++; if (ov_m !== 1'b1) begin failures++; $display("FAIL blt_latency L%0d: out_valid %b want 1", lat, ov_m); end
    e = '{taken: 1'b1, target: 32'h120, redirect: 32'h120, misp: 1'b1, illegal: 1'b0};
    checks++; if (obs !== e) begin failures++; $display("FAIL blt_result L%0d: got %h want %h", lat, obs, e); end
    retire_one();
    checks++; if (ov_m !== 1'b0) begin failures++; $display("FAIL blt_retired L%0d: out_valid %b want 0", lat, ov_m); end
    r.f = 3'b110;
    issue_and_wait(r);
    e = '{taken: 1'b0, target: 32'h120, redirect: 32'h104, misp: 1'b0, illegal: 1'b0};
    checks++; if (obs !== e || ov_m !== 1'b1) begin failures++; $display("FAIL bltu_result L%0d: got %h v=%b want %h", lat, obs, ov_m, e); end
    retire_one();
    checks++; if (cb_m !== 4'd2 || cm_m !== 4'd1) begin failures++; $display("FAIL blt_counters L%0d: got %0d/%0d want 2/1", lat, cb_m, cm_m); end
  endtask

  task automatic test_back_to_back();
    req_t r;
    exp_t q[$];
    int   nm;
    logic exp_ov;
    do_reset();
    out_ready = 1'b1;
    nm = 0;
    for (int c = 0; c < 10 + lat; c++) begin
      @(negedge clk);
      exp_ov = (c >= lat) && (c < lat + 8);
      checks++; if (ov_m !== exp_ov) begin failures++; $display("FAIL b2b_valid L%0d c=%0d: got %b want %b", lat, c, ov_m, exp_ov); end
      if (ov_m === 1'b1 && q.size() > 0) begin
        checks++; if (obs !== q[0]) begin failures++; $display("FAIL b2b_data L%0d c=%0d: got %h want %h", lat, c, obs, q[0]); end
        void'(q.pop_front());
      end
      if (c < 8) begin
        r = rand_req();
        r.f = $urandom_range(0, 1) ? 3'b001 : 3'b000;
        r.b = (c % 2 == 0) ? r.a : (r.a ^ (32'h1 << c));
        drive_req(r);
        in_valid = 1'b1;
        q.push_back(model(r));
        if (model(r).misp) nm++;
        checks++; if (in_ready_m !== 1'b1) begin failures++; $display("FAIL b2b_in_ready L%0d c=%0d: got %b want 1", lat, c, in_ready_m); end
      end else begin
        in_valid = 1'b0;
      end
    end
    checks++; if (cb_m !== 4'd8 || cm_m !== 4'(nm)) begin failures++; $display("FAIL b2b_counters L%0d: got %0d/%0d want 8/%0d", lat, cb_m, cm_m, nm); end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    req_t reqs[3];
    exp_t q[$];
    exp_t held;
    int   sent, retired;
    logic hold_valid, exp_ir, saw_low;
    do_reset();
    for (int k = 0; k < 3; k++) reqs[k] = rand_req();
    sent = 0; retired = 0; hold_valid = 1'b0; saw_low = 1'b0; held = '0;
    for (int c = 0; c < 40 && !(sent == 3 && q.size() == 0); c++) begin
      @(negedge clk);
      if (hold_valid) begin
        checks++; if (ov_m !== 1'b1 || obs !== held) begin failures++; $display("FAIL bp_stable L%0d c=%0d: got %h v=%b want %h", lat, c, obs, ov_m, held); end
      end
      out_ready = (c >= 5);
      #1;
      exp_ir = out_ready || (q.size() < lat);
      checks++; if (in_ready_m !== exp_ir) begin failures++; $display("FAIL bp_in_ready L%0d c=%0d: got %b want %b", lat, c, in_ready_m, exp_ir); end
      if (!out_ready && in_ready_m === 1'b0) saw_low = 1'b1;
      hold_valid = 1'b0;
      if (ov_m === 1'b1 && out_ready) begin
        checks++; if (q.size() == 0 || obs !== q[0]) begin failures++; $display("FAIL bp_order L%0d c=%0d: got %h queued=%0d", lat, c, obs, q.size()); end
        if (q.size() > 0) void'(q.pop_front());
        retired++;
      end else if (ov_m === 1'b1) begin
        hold_valid = 1'b1;
        held = obs;
      end
      if (sent < 3) begin
        drive_req(reqs[sent]);
        in_valid = 1'b1;
        if (in_ready_m === 1'b1) begin
          q.push_back(model(reqs[sent]));
          sent++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (!saw_low) begin failures++; $display("FAIL bp_in_ready_drop L%0d: in_ready never fell during stall", lat); end
    checks++; if (sent != 3 || q.size() != 0 || retired != 3) begin failures++; $display("FAIL bp_lost L%0d: sent=%0d retired=%0d left=%0d want 3/3/0", lat, sent, retired, q.size()); end
    checks++; if (cb_m !== 4'd3) begin failures++; $display("FAIL bp_count L%0d: got %0d want 3", lat, cb_m); end
    out_ready = 1'b0;
  endtask

  task automatic test_kill();
    req_t r;
    exp_t e;
    do_reset();
    r = rand_req(); drive_req(r); in_valid = 1'b1;
    @(negedge clk);
    r = rand_req(); drive_req(r);
    @(negedge clk);
    r = rand_req(); drive_req(r); kill = 1'b1;
    #1;
    checks++; if (in_ready_m !== 1'b1) begin failures++; $display("FAIL kill_in_ready L%0d: got %b want 1", lat, in_ready_m); end
    @(negedge clk);
    kill = 1'b0; in_valid = 1'b0;
    checks++; if (ov_m !== 1'b0) begin failures++; $display("FAIL kill_flush L%0d: out_valid %b want 0", lat, ov_m); end
    checks++; if (cb_m !== 4'd0 || cm_m !== 4'd0) begin failures++; $display("FAIL kill_counters L%0d: got %0d/%0d want 0/0", lat, cb_m, cm_m); end
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      checks++; if (ov_m !== 1'b0) begin failures++; $display("FAIL kill_discard L%0d k=%0d: out_valid %b want 0", lat, k, ov_m); end
    end
    r = rand_req();
    e = model(r);
    issue_and_wait(r);
    checks++; if (ov_m !== 1'b1 || obs !== e) begin failures++; $display("FAIL kill_recover L%0d: got %h v=%b want %h", lat, obs, ov_m, e); end
    out_ready = 1'b1; kill = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; kill = 1'b0;
    checks++; if (ov_m !== 1'b0) begin failures++; $display("FAIL kill_retire_valid L%0d: out_valid %b want 0", lat, ov_m); end
    checks++; if (cb_m !== 4'd1 || cm_m !== 4'(e.misp)) begin failures++; $display("FAIL kill_retire_count L%0d: got %0d/%0d want 1/%0d", lat, cb_m, cm_m, e.misp); end
  endtask

  task automatic test_illegal_wrap();
    req_t r;
    exp_t e;
    do_reset();
    r = '{f: 3'b011, a: 32'h5, b: 32'h5, p: 32'hFFFF_FFFC, i: 32'h8, pr: 1'b1};
    issue_and_wait(r);
    e = '{taken: 1'b0, target: 32'h4, redirect: 32'h0, misp: 1'b1, illegal: 1'b1};
    checks++; if (ov_m !== 1'b1 || obs !== e) begin failures++; $display("FAIL illegal_011 L%0d: got %h v=%b want %h", lat, obs, ov_m, e); end
    retire_one();
    r = '{f: 3'b010, a: 32'h1, b: 32'h2, p: 32'hFFFF_FFF0, i: 32'h20, pr: 1'b0};
    issue_and_wait(r);
    e = '{taken: 1'b0, target: 32'h10, redirect: 32'hFFFF_FFF4, misp: 1'b0, illegal: 1'b1};
    checks++; if (ov_m !== 1'b1 || obs !== e) begin failures++; $display("FAIL illegal_010 L%0d: got %h v=%b want %h", lat, obs, ov_m, e); end
    retire_one();
    r = '{f: 3'b000, a: 32'h77, b: 32'h77, p: 32'hFFFF_FFF0, i: 32'h40, pr: 1'b1};
    issue_and_wait(r);
    e = '{taken: 1'b1, target: 32'h30, redirect: 32'h30, misp: 1'b0, illegal: 1'b0};
    checks++; if (ov_m !== 1'b1 || obs !== e) begin failures++; $display("FAIL target_wrap L%0d: got %h v=%b want %h", lat, obs, ov_m, e); end
    retire_one();
    checks++; if (cb_m !== 4'd3 || cm_m !== 4'd1) begin failures++; $display("FAIL illegal_counted L%0d: got %0d/%0d want 3/1", lat, cb_m, cm_m); end
  endtask

  task automatic test_saturation_reset();
    req_t r;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      r = rand_req();
      r.f = 3'b000; r.b = r.a; r.pr = 1'b0;
      drive_req(r);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (lat + 1) @(negedge clk);
    checks++; if (cb_m !== 4'hF || cm_m !== 4'hF) begin failures++; $display("FAIL saturate L%0d: got %h/%h want F/F", lat, cb_m, cm_m); end
    out_ready = 1'b0;
    r = rand_req(); drive_req(r); in_valid = 1'b1;
    @(negedge clk);
    r = rand_req(); drive_req(r);
    @(negedge clk);
    checks++; if (ov_m !== 1'b1) begin failures++; $display("FAIL sat_fill L%0d: out_valid %b want 1", lat, ov_m); end
    #2 rst = 1'b1;
    #1;
    checks++; if (ov_m !== 1'b0) begin failures++; $display("FAIL async_rst_valid L%0d: out_valid %b want 0", lat, ov_m); end
    checks++; if (cb_m !== 4'h0 || cm_m !== 4'h0) begin failures++; $display("FAIL async_rst_counters L%0d: got %h/%h want 0/0", lat, cb_m, cm_m); end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ov_m !== 1'b0) begin failures++; $display("FAIL rst_discard L%0d: out_valid %b want 0", lat, ov_m); end
  endtask

  task automatic test_random();
    req_t cur;
    exp_t q[$];
    exp_t held;
    int   sent, retires, misps;
    logic hold_valid, exp_ir;
    do_reset();
    cur = rand_req();
    sent = 0; retires = 0; misps = 0; hold_valid = 1'b0; held = '0;
    for (int c = 0; c < 800 && !(sent == 80 && q.size() == 0); c++) begin
      @(negedge clk);
      if (hold_valid) begin
        checks++; if (ov_m !== 1'b1 || obs !== held) begin failures++; $display("FAIL rnd_stable L%0d c=%0d: got %h want %h", lat, c, obs, held); end
      end
      out_ready = ($urandom_range(0, 99) < 60);
      kill = ($urandom_range(0, 99) < 3);
      #1;
      exp_ir = kill || out_ready || (q.size() < lat);
      checks++; if (in_ready_m !== exp_ir) begin failures++; $display("FAIL rnd_in_ready L%0d c=%0d: got %b want %b", lat, c, in_ready_m, exp_ir); end
      hold_valid = 1'b0;
      if (ov_m === 1'b1 && out_ready) begin
        checks++; if (q.size() == 0 || obs !== q[0]) begin failures++; $display("FAIL rnd_data L%0d c=%0d: got %h queued=%0d", lat, c, obs, q.size()); end
        if (q.size() > 0) begin
          if (q[0].misp) misps++;
          void'(q.pop_front());
        end
        retires++;
      end else if (ov_m === 1'b1 && !kill) begin
        hold_valid = 1'b1;
        held = obs;
      end
      if (kill) q.delete();
      if (sent < 80 && $urandom_range(0, 99) < 70) begin
        drive_req(cur);
        in_valid = 1'b1;
        if (in_ready_m === 1'b1) begin
          if (!kill) q.push_back(model(cur));
          sent++;
          cur = rand_req();
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    checks++; if (sent != 80 || q.size() != 0) begin failures++; $display("FAIL rnd_drain L%0d: sent=%0d left=%0d", lat, sent, q.size()); end
    checks++; if (cb_m !== 4'((retires > 15) ? 15 : retires) || cm_m !== 4'((misps > 15) ? 15 : misps)) begin
      failures++; $display("FAIL rnd_counters L%0d: got %0d/%0d want %0d/%0d (saturating at 15)", lat, cb_m, cm_m, retires, misps);
    end
  endtask

  initial begin
    rst = 1'b1; kill = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0; lat = 1;
    funct3 = 3'b000; rs1 = '0; rs2 = '0; pc = '0; imm = '0; pred = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      lat = s + 1;
      test_reset();
      test_blt_bltu();
      test_back_to_back();
      test_backpressure();
      test_kill();
      test_illegal_wrap();
      test_saturation_reset();
      test_random();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
